// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and the 2-of-3 majority vote.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SUB_W      = $clog2(OVERSAMPLE);
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);

  localparam logic [SUB_W-1:0] TICK_S0  = SUB_W'(7);
  localparam logic [SUB_W-1:0] TICK_S1  = SUB_W'(8);
  localparam logic [SUB_W-1:0] TICK_S2  = SUB_W'(9);
  localparam logic [SUB_W-1:0] TICK_END = SUB_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one tick every div_i+1 clocks, re-phased by restart_i.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_i,
  input  logic             restart_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  // div_i is only sampled on reload, so a new divisor applies from the next period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else if (restart_i) begin
      cnt_q  <= div_i;
      tick_o <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q  <= div_i;
      tick_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_q - DIV_W'(1);
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: pin synchronizer, 16x oversampling with
// majority voting, RX FIFO push and frame-error / break / overrun strobes.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rx_pin_i,
  input  logic             fifo_full_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_we_o,
  output logic             frame_err_o,
  output logic             break_o,
  output logic             overrun_o,
  output logic             busy_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  rx_state_e              state_q, state_d;
  logic [SUB_W-1:0]       sub_q, sub_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [7:0]             data_d;
  logic                   we_d, ferr_d, brk_d, ovr_d;
  logic                   tick, restart_c, maj_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk       (clk),
    .reset     (reset),
    .div_i     (baud_div_i),
    .restart_i (restart_c),
    .tick_o    (tick)
  );

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    data_d    = rx_data_o;
    we_d      = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;
    ovr_d     = 1'b0;
    restart_c = 1'b0;
    maj_c     = maj3(s7_q, s8_q, rxs);

    if (!en_i) begin
      state_d = IDLE;
    end else begin
      if (tick && (state_q inside {START, DATA, STOP})) begin
        sub_d = sub_q + SUB_W'(1);
        if (sub_q == TICK_S0) s7_d = rxs;
        if (sub_q == TICK_S1) s8_d = rxs;
      end

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            restart_c = 1'b1;
            sub_d     = '0;
            state_d   = START;
          end
        end
        START: begin
          if (tick) begin
            if (sub_q == TICK_S2 && maj_c) begin
              state_d = IDLE;
            end else if (sub_q == TICK_END) begin
              state_d = DATA;
              idx_d   = '0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sub_q == TICK_S2) shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
            if (sub_q == TICK_END) begin
              idx_d = idx_q + IDX_W'(1);
              if (idx_q == IDX_LAST) state_d = STOP;
            end
          end
        end
        // decided mid stop bit so a back-to-back start edge is still caught
        STOP: begin
          if (tick && sub_q == TICK_S2) begin
            if (maj_c) begin
              data_d  = shift_q;
              ovr_d   = fifo_full_i;
              we_d    = !fifo_full_i;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              brk_d   = (shift_q == '0);
              state_d = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sub_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      rx_data_o   <= '0;
      rx_we_o     <= 1'b0;
      frame_err_o <= 1'b0;
      break_o     <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      rx_data_o   <= data_d;
      rx_we_o     <= we_d;
      frame_err_o <= ferr_d;
      break_o     <= brk_d;
      overrun_o   <= ovr_d;
      busy_o      <= (state_d != IDLE);
    end
  end

endmodule
